// File: rtl/vga_pll_sequencer.sv
// vga_pll_sequencer: sequences the pixel-clock PLL reset, qualifies lock and releases the VGA-domain reset.
module vga_pll_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             restart,
    output logic             pll_rst,
    output logic             vga_rst_n,
    output logic             ready,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] relock_count
);
    localparam int MAX_A = RST_CYCLES > LOCK_TIMEOUT ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_C = MAX_A > STABLE_CYCLES ? MAX_A : STABLE_CYCLES;
    localparam int CW    = MAX_C > 1 ? $clog2(MAX_C) : 1;
    localparam int RW    = $clog2(MAX_RETRIES + 2);
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        WAIT   = 3'd1,
        STABLE = 3'd2,
        RUN    = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [CNT_W-1:0] relock_q, relock_d;
    logic             sync1_q, lk_s_q;
    logic             pll_rst_q, vga_rst_n_q, ready_q, fault_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        if (restart) begin
            state_d = HOLD;
            cnt_d   = '0;
            retry_d = state_q == FAULT ? '0 : retry_q;
        end else begin
            case (state_q)
                HOLD: begin
                    state_d = cnt_q == RST_LAST ? WAIT : HOLD;
                    cnt_d   = cnt_q == RST_LAST ? '0 : cnt_q + 1'b1;
                end
                WAIT: begin
                    if (lk_s_q) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        retry_d = retry_q + 1'b1;
                        state_d = retry_d > RETRY_MAX ? FAULT : HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lk_s_q) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!lk_s_q) begin
                        state_d  = HOLD;
                        cnt_d    = '0;
                        relock_d = &relock_q ? relock_q : relock_q + 1'b1;
                    end
                end
                FAULT:   state_d = FAULT;
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            relock_q    <= '0;
            sync1_q     <= 1'b0;
            lk_s_q      <= 1'b0;
            pll_rst_q   <= 1'b1;
            vga_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            relock_q    <= relock_d;
            sync1_q     <= pll_locked;
            lk_s_q      <= sync1_q;
            pll_rst_q   <= state_d == HOLD;
            vga_rst_n_q <= state_d == RUN;
            ready_q     <= state_d == RUN;
            fault_q     <= state_d == FAULT;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign vga_rst_n    = vga_rst_n_q;
    assign ready        = ready_q;
    assign fault        = fault_q;
    assign state        = state_q;
    assign relock_count = relock_q;
endmodule

// File: tb/tb_vga_pll_sequencer.sv
// tb_vga_pll_sequencer: scoreboard bench; a cycle model predicts every output word, a negedge monitor compares.
module tb_vga_pll_sequencer;
    localparam int RC = 4, TO = 20, SC = 8, MR = 2, CW = 4;
    localparam int SAT = (1 << CW) - 1;
    localparam logic [10:0] RESET_WORD = 11'b1_0_0_0_000_0000;

    logic refclk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, restart = 1'b0;
    logic pll_rst, vga_rst_n, ready, fault;
    logic [2:0] state;
    logic [CW-1:0] relock_count;
    logic [10:0] dut_out;
    int n_tests = 0, n_fail = 0;

    logic [10:0] exp_q[$];
    logic [10:0] m_exp;
    logic lk_hist[$];
    logic m_lk;
    int m_phase = 0, m_elapsed = 0, m_retries = 0, m_relocks = 0;

    vga_pll_sequencer #(
        .RST_CYCLES(RC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(SC), .MAX_RETRIES(MR), .CNT_W(CW)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart),
        .pll_rst(pll_rst), .vga_rst_n(vga_rst_n), .ready(ready), .fault(fault),
        .state(state), .relock_count(relock_count)
    );

    assign dut_out = {pll_rst, vga_rst_n, ready, fault, state, relock_count};

    always #5 refclk = ~refclk;

    function automatic logic [10:0] word(int ph, int rel);
        return {ph == 0, ph == 3, ph == 3, ph == 4, 3'(ph), 4'(rel)};
    endfunction

    // Reference model: phases and elapsed-cycle counts; lock is seen two edges late.
    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_elapsed = 0; m_retries = 0; m_relocks = 0;
            lk_hist = '{1'b0, 1'b0};
            exp_q.delete();
            exp_q.push_back(word(0, 0));
        end else begin
            m_lk = lk_hist.pop_front();
            lk_hist.push_back(pll_locked);
            if (restart) begin
                if (m_phase == 4) m_retries = 0;
                m_phase = 0; m_elapsed = 0;
            end else begin
                case (m_phase)
                    0: begin
                        m_elapsed++;
                        if (m_elapsed == RC) begin m_phase = 1; m_elapsed = 0; end
                    end
                    1: if (m_lk) begin
                        m_phase = 2; m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == TO) begin
                            m_retries++;
                            m_phase = m_retries > MR ? 4 : 0;
                            m_elapsed = 0;
                        end
                    end
                    2: if (!m_lk) begin
                        m_phase = 1; m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == SC) begin m_phase = 3; m_elapsed = 0; m_retries = 0; end
                    end
                    3: if (!m_lk) begin
                        m_phase = 0; m_elapsed = 0;
                        if (m_relocks < SAT) m_relocks++;
                    end
                    default: ;
                endcase
            end
            exp_q.push_back(word(m_phase, m_relocks));
        end
    end

    always @(negedge refclk) begin
        if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            n_tests++;
            if (dut_out !== m_exp) begin
                n_fail++;
                $display("FAIL cycle_word t=%0t got %b expected %b", $time, dut_out, m_exp);
            end
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge refclk);
        #2;
    endtask

    task automatic wait_ready(string name);
        int n = 0;
        while (!ready && n < 60) begin
            tick;
            n++;
        end
        check(name, ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int cnt, n;
        logic saw_wait;
        repeat (3) tick;
        check("reset_word", dut_out, RESET_WORD);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            cnt += int'(pll_rst);
            tick;
        end
        check("pll_rst_width", cnt, RC);
        pll_locked = 1'b1;
        n = 0;
        while (!ready && n < 40) begin tick; n++; end
        check("lock_to_ready_cycles", n, 2 + 1 + SC);
        check("run_state", state, 3);
        check("run_vga_rst_n", vga_rst_n, 1);

        restart = 1'b1; tick; restart = 1'b0;
        repeat (8) tick;
        pll_locked = 1'b0; tick; pll_locked = 1'b1;
        saw_wait = 1'b0;
        n = 0;
        while (!ready && n < 40) begin tick; n++; if (state == 3'd1) saw_wait = 1'b1; end
        check("glitch_back_to_wait", saw_wait, 1);
        check("glitch_fresh_window", n, 11);
        check("glitch_no_relock", relock_count, 0);

        pll_locked = 1'b0;
        tick; check("loss_vga_edge1", vga_rst_n, 1);
        tick; check("loss_vga_edge2", vga_rst_n, 1);
        tick; check("loss_vga_edge3", vga_rst_n, 0);
        check("loss_state_hold", state, 0);
        check("loss_relock_1", relock_count, 1);
        pll_locked = 1'b1;
        wait_ready("relock_run");

        pll_locked = 1'b0; tick; tick;
        restart = 1'b1; tick; restart = 1'b0;
        check("restart_wins_state", state, 0);
        check("restart_wins_relock", relock_count, 1);
        pll_locked = 1'b1;
        wait_ready("after_restart_run");

        for (int i = 0; i < 15; i++) begin
            pll_locked = 1'b0; repeat (3) tick;
            pll_locked = 1'b1;
            wait_ready("loss_loop_run");
        end
        check("relock_saturated", relock_count, SAT);

        pll_locked = 1'b0; restart = 1'b1; tick; restart = 1'b0;
        repeat (80) tick;
        check("timeout_fault", fault, 1);
        check("timeout_pll_rst", pll_rst, 0);
        check("timeout_state", state, 4);
        pll_locked = 1'b1;
        repeat (30) tick;
        check("fault_sticky", fault, 1);
        restart = 1'b1; tick; restart = 1'b0;
        check("fault_restart_state", state, 0);
        check("fault_restart_clear", fault, 0);
        wait_ready("fault_restart_run");

        restart = 1'b1; tick; restart = 1'b0;
        repeat (7) tick;
        check("pre_reset_stable", state, 2);
        #1 rst_n = 1'b0;
        #1 check("async_reset_word", dut_out, RESET_WORD);
        tick; tick;
        rst_n = 1'b1;
        wait_ready("post_reset_run");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) pll_locked = ~pll_locked;
            restart = $urandom_range(0, 149) == 0;
            tick;
        end
        restart = 1'b0;
        repeat (2) tick;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
